// File: rtl/solver_frame_reader_if.sv
// Read port toward the solver bank plus the RGB565 pixel stream.
// master = frame reader side, slave = bank/consumer side.
interface solver_frame_reader_if;
    logic [5:0]  rd_solver_id;
    logic [18:0] rd_addr;
    logic [3:0]  rd_data_in;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [15:0] pixel_data;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        pixel_last;

    modport master (
        output rd_solver_id, rd_addr,
        output pixel_valid, pixel_data, pixel_x, pixel_y, pixel_last,
        input  rd_data_in, pixel_ready
    );

    modport slave (
        input  rd_solver_id, rd_addr,
        input  pixel_valid, pixel_data, pixel_x, pixel_y, pixel_last,
        output rd_data_in, pixel_ready
    );
endinterface

// File: rtl/solver_frame_reader.sv
// Streams a finished fractal frame from the solver result RAMs in raster order,
// mapping each 4-bit result to an RGB565 pixel on a valid/ready stream.
module solver_frame_reader #(
    parameter int unsigned NUM_SOLVERS = 1,
    parameter int unsigned NUM_COLUMNS = 640,
    parameter int unsigned NUM_ROWS    = 480
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         solve_done,
    output logic                         busy,
    solver_frame_reader_if.master        bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, OUTPUT} state_t;

    localparam logic [5:0] SID_LAST = 6'(NUM_SOLVERS - 1);
    localparam logic [9:0] X_LAST   = 10'(NUM_COLUMNS - 1);
    localparam logic [9:0] Y_LAST   = 10'(NUM_ROWS - 1);

    state_t      state_q, state_d;
    logic [5:0]  sid;
    logic [18:0] addr;
    logic [9:0]  x, y;
    logic        load, capture, advance, finish;
    logic        handshake;
    logic [15:0] colour;

    assign handshake = bus.pixel_valid & bus.pixel_ready;

    // The counters are loaded on entry to ISSUE, so the read address is already
    // on the bus during ISSUE and the bank's data lands in time for CAPTURE.
    assign bus.rd_solver_id = sid;
    assign bus.rd_addr      = addr;

    always_comb begin
        colour = '0;
        if (!bus.rd_data_in[3])
            colour = {bus.rd_data_in[2:0], 2'b00,
                      bus.rd_data_in[2:0], 3'b000,
                      bus.rd_data_in[2:0], 2'b00};
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && solve_done) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = OUTPUT;
            OUTPUT:  if (handshake) state_d = bus.pixel_last ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load    = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE:    load    = start && solve_done;
            CAPTURE: capture = 1'b1;
            OUTPUT: begin
                advance = handshake && !bus.pixel_last;
                finish  = handshake &&  bus.pixel_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sid             <= '0;
            addr            <= '0;
            x               <= '0;
            y               <= '0;
            busy            <= 1'b0;
            bus.pixel_valid <= 1'b0;
            bus.pixel_data  <= '0;
            bus.pixel_x     <= '0;
            bus.pixel_y     <= '0;
            bus.pixel_last  <= 1'b0;
        end else begin
            if (load) begin
                sid  <= '0;
                addr <= '0;
                x    <= '0;
                y    <= '0;
                busy <= 1'b1;
            end
            if (capture) begin
                bus.pixel_valid <= 1'b1;
                bus.pixel_data  <= colour;
                bus.pixel_x     <= x;
                bus.pixel_y     <= y;
                bus.pixel_last  <= (x == X_LAST) && (y == Y_LAST);
            end
            if (advance || finish) bus.pixel_valid <= 1'b0;
            if (finish) busy <= 1'b0;
            if (advance) begin
                if (sid == SID_LAST) begin
                    sid  <= '0;
                    addr <= addr + 19'd1;
                end else begin
                    sid <= sid + 6'd1;
                end
                if (x == X_LAST) begin
                    x <= '0;
                    y <= y + 10'd1;
                end else begin
                    x <= x + 10'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_solver_frame_reader.sv
// Bench for solver_frame_reader: a small 4-solver 8x2 instance driven by table
// and random frames, plus a default-size instance for latency/throughput/reset.
module tb_solver_frame_reader;
    logic clock = 1'b0;
    logic reset;
    logic start_a, solve_done_a, busy_a;
    logic start_b, solve_done_b, busy_b;

    always #5 clock = ~clock;

    solver_frame_reader_if ifa ();
    solver_frame_reader_if ifb ();

    solver_frame_reader #(.NUM_SOLVERS(4), .NUM_COLUMNS(8), .NUM_ROWS(2)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .solve_done(solve_done_a),
        .busy(busy_a), .bus(ifa)
    );

    solver_frame_reader dut_b (
        .clock(clock), .reset(reset), .start(start_b), .solve_done(solve_done_b),
        .busy(busy_b), .bus(ifb)
    );

    // Bank models: one registered RAM per solver, combinational mux on solver id.
    logic [3:0] vala [16];
    logic [3:0] valb [128];
    logic [3:0] qa [4];
    logic [3:0] qb;

    always @(posedge clock) begin
        for (int s = 0; s < 4; s++) qa[s] <= vala[(int'(ifa.rd_addr) * 4 + s) % 16];
        qb <= valb[ifb.rd_addr[6:0]];
    end
    assign ifa.rd_data_in = qa[ifa.rd_solver_id[1:0]];
    assign ifb.rd_data_in = qb;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [15:0] ref_colour(input logic [3:0] v);
        int n;
        n = int'(v);
        if (n > 7) n -= 16;
        if (n <= 0) return 16'h0000;
        return 16'(n * 8192 + n * 256 + n * 4);
    endfunction

    typedef struct {
        logic [3:0]  v;
        logic [15:0] exp;
    } colour_vec_t;
    colour_vec_t tv [8];
    logic [15:0] exp_a [16];

    // One frame on the 4-solver 8x2 instance, with random ready, one 5-cycle
    // stall at stall_pix, and optional start/solve_done noise mid-frame.
    task automatic frame_a(input int rdy_pct, input int stall_pix, input bit poke);
        int p, cyc, stl;
        bit hold, stalled;
        logic [63:0] snap, cur;
        p = 0; cyc = 0; stl = 0; hold = 0; stalled = 0; snap = '0;
        start_a = 1'b1; solve_done_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        while (p < 16 && cyc < 600) begin
            cur = {2'b00, ifa.pixel_data, ifa.pixel_x, ifa.pixel_y, ifa.pixel_last,
                   ifa.rd_solver_id, ifa.rd_addr};
            chk("a_busy", busy_a, 1);
            if (hold) begin
                chk("a_hold_valid", ifa.pixel_valid, 1);
                chk("a_hold_fields", cur, snap);
            end
            if (poke) begin
                start_a = 1'($urandom_range(1));
                solve_done_a = 1'($urandom_range(1));
            end
            if (ifa.pixel_valid && p == stall_pix && !stalled) begin
                stl = 5; stalled = 1;
            end
            if (stl > 0) begin
                ifa.pixel_ready = 1'b0;
                stl--;
            end else begin
                ifa.pixel_ready = ($urandom_range(99) < rdy_pct);
            end
            if (ifa.pixel_valid && ifa.pixel_ready) begin
                chk("a_x", ifa.pixel_x, p % 8);
                chk("a_y", ifa.pixel_y, p / 8);
                chk("a_last", ifa.pixel_last, (p == 15));
                chk("a_id", ifa.rd_solver_id, p % 4);
                chk("a_addr", ifa.rd_addr, p / 4);
                chk("a_data", ifa.pixel_data, exp_a[p]);
                p++;
            end
            hold = ifa.pixel_valid && !ifa.pixel_ready;
            snap = cur;
            @(negedge clock);
            cyc++;
        end
        start_a = 1'b0; solve_done_a = 1'b1; ifa.pixel_ready = 1'b0;
        chk("a_frame_pixels", p, 16);
        chk("a_busy_after", busy_a, 0);
        chk("a_valid_after", ifa.pixel_valid, 0);
    endtask

    task automatic check_reset_b(input string nm);
        chk({nm, "_valid"}, ifb.pixel_valid, 0);
        chk({nm, "_data"}, ifb.pixel_data, 0);
        chk({nm, "_xy"}, {ifb.pixel_x, ifb.pixel_y}, 0);
        chk({nm, "_last"}, ifb.pixel_last, 0);
        chk({nm, "_busy"}, busy_b, 0);
        chk({nm, "_rd"}, {ifb.rd_solver_id, ifb.rd_addr}, 0);
    endtask

    initial begin
        int p, cyc;
        tv[0] = '{4'hF, 16'h0000};
        tv[1] = '{4'h0, 16'h0000};
        tv[2] = '{4'h1, 16'h2104};
        tv[3] = '{4'h7, 16'hE71C};
        tv[4] = '{4'h8, 16'h0000};
        tv[5] = '{4'h3, 16'h630C};
        tv[6] = '{4'h5, 16'hA514};
        tv[7] = '{4'h2, 16'h4208};
        for (int i = 0; i < 128; i++) valb[i] = 4'($urandom);
        for (int i = 0; i < 16; i++) vala[i] = 4'($urandom);

        reset = 1'b1;
        start_a = 1'b0; solve_done_a = 1'b0; ifa.pixel_ready = 1'b0;
        start_b = 1'b0; solve_done_b = 1'b0; ifb.pixel_ready = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_b("rst_b");
        chk("rst_a", {ifa.pixel_valid, ifa.pixel_data, ifa.pixel_last, busy_a,
                      ifa.rd_solver_id, ifa.rd_addr}, 0);
        reset = 1'b0;
        @(negedge clock);

        // start without solve_done is dropped, and not remembered afterwards.
        start_a = 1'b1; solve_done_a = 1'b0;
        @(negedge clock);
        start_a = 1'b0; solve_done_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("nodone_busy", busy_a, 0);
            chk("nodone_valid", ifa.pixel_valid, 0);
            chk("nodone_rd", {ifa.rd_solver_id, ifa.rd_addr}, 0);
            @(negedge clock);
        end

        // Table-driven colour frame with a 5-cycle stall on pixel 5.
        for (int i = 0; i < 16; i++) begin
            vala[i]  = tv[i % 8].v;
            exp_a[i] = tv[i % 8].exp;
        end
        frame_a(100, 5, 1'b0);

        // Random frames checked against the colour model, with mid-frame noise.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 16; i++) begin
                vala[i]  = 4'($urandom);
                exp_a[i] = ref_colour(vala[i]);
            end
            frame_a(60, int'($urandom_range(15)), 1'b1);
            repeat (2) @(negedge clock);
        end

        // Default instance: latency, 3-clock cadence, then abort in CAPTURE of pixel 100.
        ifb.pixel_ready = 1'b1;
        start_b = 1'b1; solve_done_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        chk("b_issue_rd", {ifb.rd_solver_id, ifb.rd_addr}, 0);
        p = 0; cyc = 0;
        while (p < 100 && cyc < 400) begin
            chk("b_busy", busy_b, 1);
            if (ifb.pixel_valid) begin
                chk("b_cadence", cyc, 2 + 3 * p);
                chk("b_x", ifb.pixel_x, p);
                chk("b_y", ifb.pixel_y, 0);
                chk("b_rd", {ifb.rd_solver_id, ifb.rd_addr}, p);
                chk("b_data", ifb.pixel_data, ref_colour(valb[p]));
                p++;
            end
            @(negedge clock);
            cyc++;
        end
        chk("b_reach_100", p, 100);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_reset_b("abort_b");

        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        cyc = 0;
        while (!ifb.pixel_valid && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        chk("b2_latency", cyc, 2);
        chk("b2_xy", {ifb.pixel_x, ifb.pixel_y}, 0);
        chk("b2_rd", {ifb.rd_solver_id, ifb.rd_addr}, 0);
        chk("b2_data", ifb.pixel_data, ref_colour(valb[0]));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
